// File: rtl/alu_sequencer.sv
// Operation sequencer for the 16-bit ALU: issues single-cycle ops and iterates
// the ALU for 32-bit add and 16x16 shift-add multiply, returning results over valid/ready.
module alu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [15:0] req_a_hi,
  input  logic [15:0] req_b_hi,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_lo,
  output logic [15:0] rsp_hi,
  output logic        rsp_cf,
  output logic        rsp_sf,
  output logic        rsp_zf,
  output logic        busy,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_ci,
  output logic        alu_nb,
  output logic        alu_ic,
  output logic        alu_na,
  output logic        alu_xo,
  output logic        alu_no,
  output logic        alu_sr,
  output logic        alu_ss,
  input  logic [15:0] alu_out,
  input  logic        alu_cf,
  input  logic        alu_sf,
  input  logic        alu_zf
);

  typedef enum logic [2:0] {IDLE, EXEC, ADD_LO, ADD_HI, MUL, RESP} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_ADD32, OP_MUL
  } op_t;

  state_t      state, state_next;
  op_t         op;
  logic [15:0] a, b, a_hi, b_hi;
  logic        carry;
  logic [3:0]  step;
  logic [15:0] acc, mreg;
  logic [15:0] acc_next, mreg_next;

  // One shift-add step: the 33-bit {carry, sum, multiplier} shifts right by one.
  assign acc_next  = {alu_cf, alu_out[15:1]};
  assign mreg_next = {alu_out[0], mreg[15:1]};

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    alu_a  = '0;
    alu_b  = '0;
    alu_ci = 1'b0;
    alu_nb = 1'b0;
    alu_ic = 1'b0;
    alu_na = 1'b0;
    alu_xo = 1'b0;
    alu_no = 1'b0;
    alu_sr = 1'b0;
    alu_ss = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          case (op_t'(req_op))
            OP_ADD32: state_next = ADD_LO;
            OP_MUL:   state_next = MUL;
            default:  state_next = EXEC;
          endcase
        end
      end
      EXEC: begin
        alu_a = a;
        alu_b = b;
        case (op)
          OP_SUB: begin
            alu_ci = 1'b1;
            alu_nb = 1'b1;
          end
          OP_AND: begin
            alu_nb = 1'b1;
            alu_ic = 1'b1;
            alu_na = 1'b1;
            alu_xo = 1'b1;
            alu_no = 1'b1;
          end
          OP_OR: begin
            alu_ic = 1'b1;
            alu_xo = 1'b1;
          end
          OP_XOR: alu_ic = 1'b1;
          OP_SRA: begin
            alu_b  = '0;
            alu_ic = 1'b1;
            alu_sr = 1'b1;
            alu_ss = 1'b1;
          end
          default: ;
        endcase
        state_next = RESP;
      end
      ADD_LO: begin
        alu_a      = a;
        alu_b      = b;
        state_next = ADD_HI;
      end
      ADD_HI: begin
        alu_a      = a_hi;
        alu_b      = b_hi;
        alu_ci     = carry;
        state_next = RESP;
      end
      MUL: begin
        alu_a = acc;
        alu_b = mreg[0] ? a : '0;
        if (step == 4'd15) state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op     <= OP_ADD;
      a      <= '0;
      b      <= '0;
      a_hi   <= '0;
      b_hi   <= '0;
      carry  <= 1'b0;
      step   <= '0;
      acc    <= '0;
      mreg   <= '0;
      rsp_lo <= '0;
      rsp_hi <= '0;
      rsp_cf <= 1'b0;
      rsp_sf <= 1'b0;
      rsp_zf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op   <= op_t'(req_op);
            a    <= req_a;
            b    <= req_b;
            a_hi <= req_a_hi;
            b_hi <= req_b_hi;
            acc  <= '0;
            mreg <= req_b;
            step <= '0;
          end
        end
        EXEC: begin
          rsp_lo <= alu_out;
          rsp_hi <= '0;
          rsp_cf <= alu_cf;
          rsp_sf <= alu_sf;
          rsp_zf <= alu_zf;
        end
        ADD_LO: begin
          rsp_lo <= alu_out;
          carry  <= alu_cf;
        end
        ADD_HI: begin
          rsp_hi <= alu_out;
          rsp_cf <= alu_cf;
          rsp_sf <= alu_out[15];
          rsp_zf <= (rsp_lo == 16'h0000) && (alu_out == 16'h0000);
        end
        MUL: begin
          acc  <= acc_next;
          mreg <= mreg_next;
          step <= step + 4'd1;
          if (step == 4'd15) begin
            rsp_hi <= acc_next;
            rsp_lo <= mreg_next;
            rsp_cf <= 1'b0;
            rsp_sf <= acc_next[15];
            rsp_zf <= ({acc_next, mreg_next} == 32'h0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU stands in for the real one,
// and an arithmetic reference model predicts every response.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a, req_b, req_a_hi, req_b_hi;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_lo, rsp_hi;
  logic        rsp_cf, rsp_sf, rsp_zf;
  logic        busy;
  logic [15:0] alu_a, alu_b;
  logic        alu_ci, alu_nb, alu_ic, alu_na, alu_xo, alu_no, alu_sr, alu_ss;
  logic [15:0] alu_out;
  logic        alu_cf, alu_sf, alu_zf;

  int unsigned checks = 0;
  int unsigned errors = 0;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_a_hi(req_a_hi), .req_b_hi(req_b_hi),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_cf(rsp_cf), .rsp_sf(rsp_sf), .rsp_zf(rsp_zf),
    .busy(busy), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ci(alu_ci), .alu_nb(alu_nb), .alu_ic(alu_ic), .alu_na(alu_na),
    .alu_xo(alu_xo), .alu_no(alu_no), .alu_sr(alu_sr), .alu_ss(alu_ss),
    .alu_out(alu_out), .alu_cf(alu_cf), .alu_sf(alu_sf), .alu_zf(alu_zf)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: optional operand inversion, add or (carry-inhibited) xor/or,
  // optional output inversion, optional right shift (arithmetic when ss).
  logic [15:0] m_aa, m_bb, m_r;
  logic        m_c;
  always_comb begin
    m_aa = alu_na ? ~alu_a : alu_a;
    m_bb = alu_nb ? ~alu_b : alu_b;
    m_c  = 1'b0;
    m_r  = '0;
    if (alu_ic) m_r = alu_xo ? (m_aa | m_bb) : (m_aa ^ m_bb);
    else {m_c, m_r} = {1'b0, m_aa} + {1'b0, m_bb} + {16'h0000, alu_ci};
    if (alu_no) m_r = ~m_r;
    if (alu_sr) m_r = {alu_ss & m_r[15], m_r[15:1]};
    alu_out = m_r;
    alu_cf  = m_c;
    alu_sf  = m_r[15];
    alu_zf  = (m_r == 16'h0000);
  end

  wire [7:0]  ctrl    = {alu_ci, alu_nb, alu_ic, alu_na, alu_xo, alu_no, alu_sr, alu_ss};
  wire [39:0] alu_bus = {alu_a, alu_b, ctrl};
  wire [34:0] rsp_bus = {rsp_hi, rsp_lo, rsp_cf, rsp_sf, rsp_zf};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ctrl_word(input logic [2:0] op);
    case (op)
      3'd1:    return 8'b1100_0000;
      3'd2:    return 8'b0111_1100;
      3'd3:    return 8'b0010_1000;
      3'd4:    return 8'b0010_0000;
      3'd5:    return 8'b0010_0011;
      default: return 8'b0000_0000;
    endcase
  endfunction

  // Expected {hi, lo, cf, sf, zf} from the arithmetic meaning of each op.
  function automatic logic [34:0] ref_model(input logic [2:0] op,
      input logic [15:0] a, b, ahi, bhi);
    logic [16:0]        s17;
    logic [32:0]        s33;
    logic [31:0]        p;
    logic signed [15:0] sa;
    logic [15:0]        lo;
    logic               cf;
    lo = '0;
    cf = 1'b0;
    case (op)
      3'd0: begin s17 = {1'b0, a} + {1'b0, b}; lo = s17[15:0]; cf = s17[16]; end
      3'd1: begin s17 = {1'b0, a} + {1'b0, ~b} + 17'd1; lo = s17[15:0]; cf = s17[16]; end
      3'd2: lo = a & b;
      3'd3: lo = a | b;
      3'd4: lo = a ^ b;
      3'd5: begin sa = a; sa = sa >>> 1; lo = sa; end
      3'd6: begin
        s33 = {1'b0, ahi, a} + {1'b0, bhi, b};
        return {s33[31:0], s33[32], s33[31], s33[31:0] == 32'h0};
      end
      default: begin
        p = 32'(a) * 32'(b);
        return {p, 1'b0, p[31], p == 32'h0};
      end
    endcase
    return {16'h0000, lo, cf, lo[15], lo == 16'h0000};
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [15:0] a, b, ahi, bhi,
                        input int unsigned hold);
    logic [34:0] exp, snap;
    logic [16:0] lo_sum;
    int unsigned lat, cyc;
    exp    = ref_model(op, a, b, ahi, bhi);
    lo_sum = {1'b0, a} + {1'b0, b};
    lat    = (op == 3'd6) ? 2 : (op == 3'd7) ? 16 : 1;
    check("ready_before_req", req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_a_hi = ahi; req_b_hi = bhi;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = 16'($urandom); req_b = 16'($urandom);
    req_a_hi = 16'($urandom); req_b_hi = 16'($urandom);
    check("busy_ready_after_accept", {busy, req_ready}, 2'b10);
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      if (op <= 3'd5 && cyc == 0)
        check("ctrl_word", alu_bus, {a, (op == 3'd5) ? 16'h0000 : b, ctrl_word(op)});
      if (op == 3'd6 && cyc == 1)
        check("add32_hi_ci", {alu_a, alu_b, alu_ci}, {ahi, bhi, lo_sum[16]});
      check("busy_in_op", busy, 1'b1);
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, lat);
    check("rsp_data", rsp_bus, exp);
    check("alu_zero_in_resp", alu_bus, 40'h0);
    snap = rsp_bus;
    repeat (hold) begin
      req_valid = 1'($urandom_range(0, 1));
      req_op = 3'($urandom); req_a = 16'($urandom);
      @(posedge clk); #1;
      check("hold_stable", {rsp_valid, req_ready, rsp_bus}, {2'b10, snap});
    end
    req_valid = 1'($urandom_range(0, 1));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("after_handshake", {rsp_valid, req_ready, busy}, 3'b010);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_op = '0;
    req_a = '0; req_b = '0; req_a_hi = '0; req_b_hi = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {req_ready, rsp_valid, busy, rsp_bus, alu_bus},
          {3'b100, 35'h0, 40'h0});
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", {req_ready, busy}, 2'b10);

    run_op(3'd0, 16'hFFFF, 16'h0001, 16'h0, 16'h0, 0);
    run_op(3'd1, 16'h0005, 16'h0007, 16'h0, 16'h0, 0);
    run_op(3'd2, 16'hF0F0, 16'h3C3C, 16'h0, 16'h0, 0);
    run_op(3'd3, 16'hF0F0, 16'h0F0F, 16'h0, 16'h0, 0);
    run_op(3'd4, 16'hAAAA, 16'hAAAA, 16'h0, 16'h0, 0);
    run_op(3'd5, 16'h8004, 16'h5A5A, 16'h0, 16'h0, 0);
    run_op(3'd6, 16'hFFFF, 16'h0001, 16'h0001, 16'h0000, 0);
    run_op(3'd7, 16'h1234, 16'h5678, 16'h0, 16'h0, 0);
    run_op(3'd7, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 0);
    run_op(3'd0, 16'h1111, 16'h2222, 16'h0, 16'h0, 5);

    // Reset in the middle of a multiply drops it with no response.
    req_valid = 1'b1; req_op = 3'd7; req_a = 16'h1234; req_b = 16'h5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_mul_reset", {rsp_valid, busy, rsp_bus, alu_bus}, {2'b00, 35'h0, 40'h0});
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_mul_reset", {req_ready, rsp_valid}, 2'b10);
    run_op(3'd0, 16'h0003, 16'h0004, 16'h0, 16'h0, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
